// File: rtl/thiele_cpu.sv
// rtl/thiele_cpu.sv - partition-accounting CPU: fetch/execute FSM with memory, logic and python handshakes.
module thiele_cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_data,
  output logic [31:0] pc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_en,
  output logic        logic_req,
  output logic [31:0] logic_addr,
  input  logic        logic_ack,
  input  logic [31:0] logic_data,
  output logic        py_req,
  output logic [31:0] py_code_addr,
  input  logic        py_ack,
  input  logic [31:0] py_result,
  output logic [31:0] cert_addr,
  output logic [31:0] status,
  output logic [31:0] error_code,
  output logic [31:0] partition_ops,
  output logic [31:0] mdl_ops,
  output logic [31:0] info_gain
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_EXECUTE    = 3'd1,
    S_MEM_WAIT   = 3'd2,
    S_LOGIC_WAIT = 3'd3,
    S_PY_WAIT    = 3'd4,
    S_HALTED     = 3'd5,
    S_ERROR      = 3'd6
  } state_t;

  localparam logic [7:0] OP_PNEW    = 8'h00;
  localparam logic [7:0] OP_PSPLIT  = 8'h01;
  localparam logic [7:0] OP_PMERGE  = 8'h02;
  localparam logic [7:0] OP_LASSERT = 8'h03;
  localparam logic [7:0] OP_MDLACC  = 8'h05;
  localparam logic [7:0] OP_XFER    = 8'h07;
  localparam logic [7:0] OP_PYEXEC  = 8'h08;
  localparam logic [7:0] OP_HALT    = 8'hFF;

  state_t      state;
  state_t      w_next_state;
  logic [31:0] mu_accumulator;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_cert;
  logic [31:0] r_err;
  logic [31:0] r_pops;
  logic [31:0] r_mdl;
  logic [31:0] r_info;
  logic [3:0]  r_num_modules;

  logic [7:0]  w_op, w_a, w_b, w_cost;
  logic [7:0]  w_nm8;
  logic        w_retire, w_err, w_pops_inc, w_mdl_inc, w_cert_load;
  logic [7:0]  w_err_code;
  logic [3:0]  w_nm_next;
  logic [31:0] w_cert_val;

  assign w_op   = r_instr[31:24];
  assign w_a    = r_instr[23:16];
  assign w_b    = r_instr[15:8];
  assign w_cost = r_instr[7:0];
  assign w_nm8  = {4'b0, r_num_modules};

  assign pc            = r_pc;
  assign cert_addr     = r_cert;
  assign error_code    = r_err;
  assign partition_ops = r_pops;
  assign mdl_ops       = r_mdl;
  assign info_gain     = r_info;
  assign status        = {16'b0, 4'b0, r_num_modules, 5'b0, state};
  assign logic_req     = (state == S_LOGIC_WAIT);
  assign py_req        = (state == S_PY_WAIT);
  assign logic_addr    = {16'b0, w_a, w_b};
  assign py_code_addr  = {16'b0, w_a, w_b};

  always_comb begin
    w_next_state = state;
    w_retire     = 1'b0;
    w_err        = 1'b0;
    w_err_code   = 8'h00;
    w_nm_next    = r_num_modules;
    w_pops_inc   = 1'b0;
    w_mdl_inc    = 1'b0;
    w_cert_load  = 1'b0;
    w_cert_val   = 32'h0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    case (state)
      S_FETCH: w_next_state = S_EXECUTE;
      S_EXECUTE: begin
        case (w_op)
          OP_PNEW: begin
            if (r_num_modules == 4'd8) begin
              w_err = 1'b1; w_err_code = 8'h01;
            end else begin
              w_nm_next = r_num_modules + 4'd1; w_pops_inc = 1'b1; w_retire = 1'b1;
            end
          end
          OP_PSPLIT: begin
            if (w_a >= w_nm8) begin
              w_err = 1'b1; w_err_code = 8'h02;
            end else if (r_num_modules == 4'd8) begin
              w_err = 1'b1; w_err_code = 8'h01;
            end else begin
              w_nm_next = r_num_modules + 4'd1; w_pops_inc = 1'b1; w_retire = 1'b1;
            end
          end
          OP_PMERGE: begin
            if (w_a >= w_nm8 || w_b >= w_nm8 || w_a == w_b) begin
              w_err = 1'b1; w_err_code = 8'h03;
            end else begin
              w_nm_next = r_num_modules - 4'd1; w_pops_inc = 1'b1; w_retire = 1'b1;
            end
          end
          OP_MDLACC: begin
            w_mdl_inc = 1'b1; w_retire = 1'b1;
          end
          OP_LASSERT: w_next_state = S_LOGIC_WAIT;
          OP_PYEXEC:  w_next_state = S_PY_WAIT;
          OP_XFER: begin
            mem_en = 1'b1;
            mem_addr = {22'b0, w_a, 2'b00};
            w_next_state = S_MEM_WAIT;
          end
          OP_HALT: w_retire = 1'b1;
          default: begin
            w_err = 1'b1; w_err_code = 8'hFF;
          end
        endcase
        if (w_err)
          w_next_state = S_ERROR;
        else if (w_retire)
          w_next_state = (w_op == OP_HALT) ? S_HALTED : S_FETCH;
      end
      // Read data arrives this cycle and is written straight back out.
      S_MEM_WAIT: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        mem_addr = {22'b0, w_b, 2'b00};
        mem_wdata = mem_rdata;
        w_retire = 1'b1;
        w_next_state = S_FETCH;
      end
      S_LOGIC_WAIT: begin
        if (logic_ack) begin
          w_cert_load = 1'b1; w_cert_val = logic_data; w_retire = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_PY_WAIT: begin
        if (py_ack) begin
          w_cert_load = 1'b1; w_cert_val = py_result; w_retire = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state          <= S_FETCH;
      mu_accumulator <= 32'h0;
      r_instr        <= 32'h0;
      r_pc           <= 32'h0;
      r_cert         <= 32'h0;
      r_err          <= 32'h0;
      r_pops         <= 32'h0;
      r_mdl          <= 32'h0;
      r_info         <= 32'h0;
      r_num_modules  <= 4'd0;
    end else begin
      state <= w_next_state;
      if (state == S_FETCH)
        r_instr <= instr_data;
      if (w_err)
        r_err <= {24'b0, w_err_code};
      if (w_retire) begin
        r_pc           <= r_pc + 32'd4;
        mu_accumulator <= mu_accumulator + {24'b0, w_cost};
        r_num_modules  <= w_nm_next;
        r_pops         <= r_pops + {31'b0, w_pops_inc};
        r_mdl          <= r_mdl + {31'b0, w_mdl_inc};
        if (w_mdl_inc)
          r_info <= r_info + {24'b0, w_b};
        if (w_cert_load)
          r_cert <= w_cert_val;
      end
    end
  end

endmodule

// File: tb/tb_thiele_cpu.sv
// tb/tb_thiele_cpu.sv - scoreboard bench for thiele_cpu with instruction ROM, data memory and ack responders.
module tb_thiele_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr_data, pc, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_we, mem_en;
  logic        logic_req, py_req;
  logic [31:0] logic_addr, py_code_addr;
  logic        logic_ack = 1'b0;
  logic        py_ack = 1'b0;
  logic [31:0] logic_data = 32'hABCD1234;
  logic [31:0] py_result = 32'h12345678;
  logic [31:0] cert_addr, status, error_code, partition_ops, mdl_ops, info_gain;

  thiele_cpu dut (
    .clk(clk), .rst_n(rst_n), .instr_data(instr_data), .pc(pc),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_en(mem_en),
    .logic_req(logic_req), .logic_addr(logic_addr), .logic_ack(logic_ack), .logic_data(logic_data),
    .py_req(py_req), .py_code_addr(py_code_addr), .py_ack(py_ack), .py_result(py_result),
    .cert_addr(cert_addr), .status(status), .error_code(error_code),
    .partition_ops(partition_ops), .mdl_ops(mdl_ops), .info_gain(info_gain)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:63];
  logic [31:0] dmem [0:15];
  assign instr_data = rom[pc[7:2]];

  int n_tests = 0;
  int n_fail = 0;
  int l_delay = 0;
  int p_delay = 0;

  typedef enum {F_PC, F_MU, F_POPS, F_MDL, F_INFO, F_CERT, F_ERR, F_STATUS} field_t;
  typedef struct {string tag; field_t f; logic [31:0] val;} exp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} mop_t;
  exp_t sb[$];
  mop_t mq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input field_t f);
    case (f)
      F_PC:    return pc;
      F_MU:    return dut.mu_accumulator;
      F_POPS:  return partition_ops;
      F_MDL:   return mdl_ops;
      F_INFO:  return info_gain;
      F_CERT:  return cert_addr;
      F_ERR:   return error_code;
      default: return status;
    endcase
  endfunction

  task automatic expect_val(input string tag, input field_t f, input logic [31:0] v);
    sb.push_back('{tag, f, v});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.f), e.val);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'hFF000000;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_until_done(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (dut.state == 3'd5 || dut.state == 3'd6) begin
        done = 1'b1;
        break;
      end
    end
    check("run_done", {31'b0, done}, 32'd1);
  endtask

  // Data memory: read data presented just after the edge that ends the request cycle.
  initial begin
    logic [31:0] rd_pend;
    mop_t m;
    rd_pend = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (mq.size() == 0) begin
          check("mem_unexpected", {31'b0, mem_en}, 32'd0);
        end else begin
          m = mq.pop_front();
          check("mem_we", {31'b0, mem_we}, {31'b0, m.we});
          check("mem_addr", mem_addr, m.addr);
          if (m.we) check("mem_wdata", mem_wdata, m.data);
        end
        if (mem_we) dmem[mem_addr[5:2]] = mem_wdata;
        else rd_pend = dmem[mem_addr[5:2]];
      end
      @(posedge clk);
      #1 mem_rdata = rd_pend;
    end
  end

  initial begin
    int lcnt;
    lcnt = 0;
    forever begin
      @(negedge clk);
      if (logic_req) begin
        if (lcnt >= l_delay) logic_ack = 1'b1;
        lcnt++;
      end else begin
        logic_ack = 1'b0;
        lcnt = 0;
      end
    end
  end

  initial begin
    int pcnt;
    pcnt = 0;
    forever begin
      @(negedge clk);
      if (py_req) begin
        if (pcnt >= p_delay) py_ack = 1'b1;
        pcnt++;
      end else begin
        py_ack = 1'b0;
        pcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    clear_rom();
    for (int i = 0; i < 16; i++) dmem[i] = 32'h10000000 + i;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_state", {29'b0, dut.state}, 32'd0);
    check("rst_status", status, 32'h0);
    check("rst_mu", dut.mu_accumulator, 32'h0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_reqs", {30'b0, logic_req, py_req}, 32'd0);

    // Full reference program.
    rom[0] = 32'h00000001; rom[1] = 32'h00000001; rom[2] = 32'h01000002;
    rom[3] = 32'h02000103; rom[4] = 32'h05000504; rom[5] = 32'h03000001;
    rom[6] = 32'h08000001; rom[7] = 32'h07000101; rom[8] = 32'h05000300;
    rom[9] = 32'hFF000000;
    dmem[0] = 32'hCAFE0001;
    l_delay = 0; p_delay = 0;
    mq.push_back('{1'b0, 32'h0, 32'h0});
    mq.push_back('{1'b1, 32'h4, 32'hCAFE0001});
    expect_val("prog_pc", F_PC, 32'h28);
    expect_val("prog_pops", F_POPS, 32'd4);
    expect_val("prog_mdl", F_MDL, 32'd2);
    expect_val("prog_info", F_INFO, 32'd8);
    expect_val("prog_mu", F_MU, 32'd14);
    expect_val("prog_cert", F_CERT, 32'h12345678);
    expect_val("prog_err", F_ERR, 32'h0);
    expect_val("prog_status", F_STATUS, 32'h00000205);
    @(negedge clk); rst_n = 1'b0;
    run_until_done(200);
    drain();
    check("xfer_dmem", dmem[1], 32'hCAFE0001);
    repeat (4) @(negedge clk);
    expect_val("halt_frozen_pc", F_PC, 32'h28);
    drain();

    // Nine PNEW overflow.
    hold_reset();
    clear_rom();
    for (int i = 0; i < 9; i++) rom[i] = 32'h00000001;
    expect_val("ovf_err", F_ERR, 32'h1);
    expect_val("ovf_status", F_STATUS, 32'h00000806);
    expect_val("ovf_pc", F_PC, 32'h20);
    expect_val("ovf_pops", F_POPS, 32'd8);
    expect_val("ovf_mu", F_MU, 32'd8);
    rst_n = 1'b0;
    run_until_done(100);
    repeat (5) @(negedge clk);
    drain();

    // Illegal opcode.
    hold_reset();
    clear_rom();
    rom[0] = 32'h42000005;
    expect_val("ill_err", F_ERR, 32'hFF);
    expect_val("ill_pc", F_PC, 32'h0);
    expect_val("ill_mu", F_MU, 32'h0);
    expect_val("ill_status", F_STATUS, 32'h00000006);
    rst_n = 1'b0;
    run_until_done(20);
    drain();

    // LASSERT with ack withheld for 20 cycles.
    hold_reset();
    clear_rom();
    rom[0] = 32'h03ABCD01;
    l_delay = 20;
    rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = logic_req;
    end
    check("lreq_seen", {31'b0, seen}, 32'd1);
    check("lreq_addr", logic_addr, 32'h0000ABCD);
    for (int i = 0; i < 20; i++) begin
      check("lreq_held", {31'b0, logic_req}, 32'd1);
      check("lwait_pc", pc, 32'h0);
      @(negedge clk);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = !logic_req;
    end
    check("lreq_dropped", {31'b0, seen}, 32'd1);
    check("lack_pc", pc, 32'h4);
    check("lack_cert", cert_addr, 32'hABCD1234);
    expect_val("lassert_pc", F_PC, 32'h8);
    expect_val("lassert_mu", F_MU, 32'd1);
    run_until_done(20);
    drain();
    l_delay = 0;

    // Reset in the middle of a python handshake.
    hold_reset();
    clear_rom();
    rom[0] = 32'h08000001;
    p_delay = 1000;
    rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = py_req;
    end
    check("preq_seen", {31'b0, seen}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("prst_req", {31'b0, py_req}, 32'd0);
    check("prst_pc", pc, 32'h0);
    check("prst_state", {29'b0, dut.state}, 32'd0);
    check("prst_status", status, 32'h0);
    check("prst_mu", dut.mu_accumulator, 32'h0);
    p_delay = 0;
    rom[0] = 32'hFF000002;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("restart_state", {29'b0, dut.state}, 32'd1);
    check("restart_pc", pc, 32'h0);
    expect_val("restart_end_pc", F_PC, 32'h4);
    expect_val("restart_end_mu", F_MU, 32'd2);
    run_until_done(20);
    drain();
    check("mem_ops_left", mq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/thiele_cpu.md
THIELE_CPU -- requirements
Module: thiele_cpu

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous reset, active-HIGH despite the name (rst_n=1 resets).
REQ-003 SHALL have ports: instr_data in 32 instruction word at pc (combinational); pc out 32 byte address.
REQ-004 SHALL have ports: mem_addr out 32; mem_wdata out 32; mem_rdata in 32 (valid the cycle after a read request); mem_we out 1; mem_en out 1.
REQ-005 SHALL have ports: logic_req out 1; logic_addr out 32; logic_ack in 1; logic_data in 32.
REQ-006 SHALL have ports: py_req out 1; py_code_addr out 32; py_ack in 1; py_result in 32.
REQ-007 SHALL have ports: cert_addr, status, error_code, partition_ops, mdl_ops, info_gain, all out 32.
REQ-008 SHALL keep internal registers named state (3 bits) and mu_accumulator (32 bits), reachable hierarchically.

Function
REQ-009 Instruction = opcode[31:24], a[23:16], b[15:8], cost[7:0].
REQ-010 Opcodes: 00 PNEW, 01 PSPLIT, 02 PMERGE, 03 LASSERT, 05 MDLACC, 07 XFER, 08 PYEXEC, FF HALT; any other opcode is illegal.
REQ-011 States: FETCH=0, EXECUTE=1, MEM_WAIT=2, LOGIC_WAIT=3, PY_WAIT=4, HALTED=5, ERROR=6.
REQ-012 FETCH latches instr_data -> EXECUTE; simple ops retire in EXECUTE (2 cycles/instruction).
REQ-013 On retire: pc += 4; mu_accumulator += cost; return to FETCH, except HALT -> HALTED.
REQ-014 Internal num_modules counter, 0..8.
REQ-015 PNEW: num_modules==8 -> error 1; else num_modules+1.
REQ-016 PSPLIT: a>=num_modules -> error 2; num_modules==8 -> error 1; else num_modules+1.
REQ-017 PMERGE: a or b >= num_modules, or a==b -> error 3; else num_modules-1.
REQ-018 PNEW, PSPLIT and PMERGE each increment partition_ops on success.
REQ-019 MDLACC: mdl_ops+1; info_gain += b.
REQ-020 LASSERT: logic_req=1, logic_addr={16'b0,a,b}; hold in LOGIC_WAIT until logic_ack sampled 1; then req=0 same edge, cert_addr<=logic_data, retire.
REQ-021 PYEXEC: same handshake on py_req/py_ack with py_code_addr={16'b0,a,b}; cert_addr<=py_result.
REQ-022 XFER: cycle 1 mem_en=1, mem_we=0, mem_addr={22'b0,a,2'b00}; MEM_WAIT; next cycle mem_en=1, mem_we=1, mem_addr={22'b0,b,2'b00}, mem_wdata=sampled mem_rdata; retire.
REQ-023 mem_en and mem_we SHALL be 0 in all other cycles.
REQ-024 Request handshakes have no timeout; waiting states persist until ack or reset.
REQ-025 Illegal opcode -> error_code=FF.
REQ-026 Any error: state ERROR, no retire, pc/counters/mu unchanged, latched until reset.
REQ-027 HALT: pc+4, state HALTED, no further fetch, outputs frozen.
REQ-028 Counters and mu_accumulator SHALL wrap modulo 2^32.
REQ-029 status = {16'b0, 4'b0, num_modules[3:0], 5'b0, state}.

Reset
REQ-030 Reset SHALL clear pc, counters, cert_addr, error_code, num_modules and mu_accumulator to 0, state=FETCH, and drive all reqs/mem_en/mem_we to 0, immediately and mid-handshake.
REQ-031 First fetch SHALL occur at pc=0 on the first rising edge after release.

Verification
REQ-032 Program 0:PNEW c1, 4:PNEW c1, 8:PSPLIT a0 c2, C:PMERGE a0 b1 c3, 10:MDLACC b5 c4, 14:LASSERT c1, 18:PYEXEC c1, 1C:XFER a0 b1 c1, 20:MDLACC b3 c0, 24:HALT; env acks with ABCD1234/12345678 -> pc=0x28, partition_ops=4, mdl_ops=2, info_gain=8, mu_accumulator=14, cert_addr=12345678, error_code=0.
REQ-033 Nine PNEW -> error_code=1, state=ERROR, pc=0x20, partition_ops=8.
REQ-034 Opcode 0x42 at 0 -> error_code=FF, pc=0, mu_accumulator=0.
REQ-035 LASSERT with logic_ack withheld 20 cycles -> logic_req high all 20 cycles, pc unchanged; ack -> req low, pc+4.
REQ-036 Reset asserted during PY_WAIT -> py_req=0 and all registers 0 immediately; restart at pc=0.
